// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath: default fixed-point format
// and the input framer's state encoding.
package nn_pkg;

  localparam int unsigned NN_N_DEFAULT = 16;
  localparam int unsigned NN_Q_DEFAULT = 13;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    FIRE    = 2'd2,
    WAIT    = 2'd3
  } framer_state_t;

endpackage

// File: rtl/nn_framer_watchdog.sv
// WAIT-state watchdog for nn_input_framer: counts cycles spent waiting and flags
// the cycle in which the count reaches TIMEOUT_CYCLES-1.
module nn_framer_watchdog
  import nn_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic wait_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter is held at zero outside WAIT, so every WAIT entry starts from 0.
  always_comb begin
    cnt_d = '0;
    if (wait_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = wait_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/nn_input_framer.sv
// Serial valid/ready feature stream to parallel NUM_OF_INPUTS-word frame with a
// fire/done handshake to the network. Optional WAIT watchdog: NN_FRAMER_TIMEOUT_EN.
module nn_input_framer
  import nn_pkg::*;
#(
  parameter int unsigned Q              = NN_Q_DEFAULT,
  parameter int unsigned N              = NN_N_DEFAULT,
  parameter int unsigned NUM_OF_INPUTS  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [N-1:0] s_data_i,
  input  logic         s_valid_i,
  input  logic         s_last_i,
  output logic         s_ready_o,
  output logic [N-1:0] data_out_o [0:NUM_OF_INPUTS-1],
  output logic         fire_o,
  input  logic         nn_done_i,
  output logic         busy_o,
  output logic         frame_err_o,
  output logic         timeout_o
);

  localparam int unsigned IDX_W = (NUM_OF_INPUTS > 2) ? $clog2(NUM_OF_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OF_INPUTS - 1);

  if (NUM_OF_INPUTS < 2 || Q >= N || TIMEOUT_CYCLES < 2) begin : g_param_err
    $error("nn_input_framer: unsupported parameter combination");
  end

  framer_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     data_q [0:NUM_OF_INPUTS-1];
  logic [N-1:0]     data_d [0:NUM_OF_INPUTS-1];
  logic             ready_q, ready_d;
  logic             fire_q, fire_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;
  logic             xfer_c;
  logic             expire_c;

`ifdef NN_FRAMER_TIMEOUT_EN
  nn_framer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .wait_i   (state_q == WAIT),
    .expire_c (expire_c)
  );
`else
  assign expire_c = 1'b0;
`endif

  assign xfer_c = s_valid_i && ready_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    err_d     = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (xfer_c) begin
          data_d[idx_q] = s_data_i;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = s_last_i ? FIRE : DRAIN;
            err_d   = !s_last_i;
          end else if (s_last_i) begin
            // Short frame: keep the partial words, restart at slot 0.
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (xfer_c && s_last_i) begin
          state_d = COLLECT;
        end
      end
      FIRE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Done takes priority over a coincident watchdog expiry.
        if (nn_done_i) begin
          state_d = COLLECT;
        end else if (expire_c) begin
          state_d   = COLLECT;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase

    ready_d = (state_d == COLLECT) || (state_d == DRAIN);
    busy_d  = (state_d == FIRE) || (state_d == WAIT);
    fire_d  = (state_d == FIRE);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      data_q    <= '{default: '0};
      ready_q   <= 1'b1;
      fire_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      fire_q    <= fire_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign s_ready_o   = ready_q;
  assign data_out_o  = data_q;
  assign fire_o      = fire_q;
  assign busy_o      = busy_q;
  assign frame_err_o = err_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_nn_input_framer.sv
// Directed bench for nn_input_framer; TIMEOUT_CYCLES=8 so the watchdog steps run
// quickly when NN_FRAMER_TIMEOUT_EN is defined.
module tb_nn_input_framer;

  localparam int unsigned N  = 16;
  localparam int unsigned NI = 4;
  localparam int unsigned TO = 8;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic [N-1:0] s_data_i;
  logic         s_valid_i;
  logic         s_last_i;
  logic         s_ready_o;
  logic [N-1:0] data_out_o [0:NI-1];
  logic         fire_o;
  logic         nn_done_i;
  logic         busy_o;
  logic         frame_err_o;
  logic         timeout_o;

  int checks   = 0;
  int failures = 0;

  nn_input_framer #(
    .Q(13), .N(N), .NUM_OF_INPUTS(NI), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_last_i    (s_last_i),
    .s_ready_o   (s_ready_o),
    .data_out_o  (data_out_o),
    .fire_o      (fire_o),
    .nn_done_i   (nn_done_i),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [N-1:0] w0, input logic [N-1:0] w1,
                         input logic [N-1:0] w2, input logic [N-1:0] w3);
    chk({tag, "_w0"}, 32'(data_out_o[0]), 32'(w0));
    chk({tag, "_w1"}, 32'(data_out_o[1]), 32'(w1));
    chk({tag, "_w2"}, 32'(data_out_o[2]), 32'(w2));
    chk({tag, "_w3"}, 32'(data_out_o[3]), 32'(w3));
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  // Presents one word (valid left high) and advances to the next falling edge.
  task automatic send_word(input logic [N-1:0] d, input logic last);
    s_data_i  = d;
    s_last_i  = last;
    s_valid_i = 1'b1;
    cyc();
  endtask

  // Four-word frame; returns at the falling edge of the expected fire cycle.
  task automatic send_frame4(input logic [N-1:0] w0, input logic [N-1:0] w1,
                             input logic [N-1:0] w2, input logic [N-1:0] w3);
    send_word(w0, 1'b0);
    send_word(w1, 1'b0);
    send_word(w2, 1'b0);
    send_word(w3, 1'b1);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  // From the fire cycle: enter WAIT, pulse done, return at the first COLLECT cycle.
  task automatic release_nn();
    cyc();
    nn_done_i = 1'b1;
    cyc();
    nn_done_i = 1'b0;
  endtask

  initial begin
    rstn_i    = 1'b0;
    s_data_i  = '0;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    nn_done_i = 1'b0;
    cyc();
    cyc();
    rstn_i = 1'b1;

    // Reset state
    chk("rst_ready", 32'(s_ready_o), 32'd1);
    chk("rst_fire", 32'(fire_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(frame_err_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk_vec("rst_data", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // Basic frame with valid held high
    send_frame4(16'h2000, 16'hE000, 16'h1000, 16'h0800);
    chk("f1_fire", 32'(fire_o), 32'd1);
    chk("f1_busy", 32'(busy_o), 32'd1);
    chk("f1_ready", 32'(s_ready_o), 32'd0);
    chk("f1_err", 32'(frame_err_o), 32'd0);
    chk_vec("f1_data", 16'h2000, 16'hE000, 16'h1000, 16'h0800);

    // WAIT: a pending word must not be consumed before done
    s_data_i  = 16'h1111;
    s_last_i  = 1'b0;
    s_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("wait_ready", 32'(s_ready_o), 32'd0);
      chk("wait_fire", 32'(fire_o), 32'd0);
      chk("wait_busy", 32'(busy_o), 32'd1);
      chk("wait_hold_w0", 32'(data_out_o[0]), 32'h2000);
    end
    nn_done_i = 1'b1;
    cyc();
    nn_done_i = 1'b0;
    chk("done_ready", 32'(s_ready_o), 32'd1);
    chk("done_busy", 32'(busy_o), 32'd0);
    chk_vec("done_hold", 16'h2000, 16'hE000, 16'h1000, 16'h0800);
    cyc();
    chk("accept_after_done", 32'(data_out_o[0]), 32'h1111);

    // Short frame: last on the 2nd word
    send_word(16'h2222, 1'b1);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    chk("short_err", 32'(frame_err_o), 32'd1);
    chk("short_fire", 32'(fire_o), 32'd0);
    chk("short_ready", 32'(s_ready_o), 32'd1);
    cyc();
    chk("short_err_pulse", 32'(frame_err_o), 32'd0);
    chk("short_fire2", 32'(fire_o), 32'd0);
    chk_vec("short_data", 16'h1111, 16'h2222, 16'h1000, 16'h0800);

    send_frame4(16'hA001, 16'hA002, 16'hA003, 16'hA004);
    chk("after_short_fire", 32'(fire_o), 32'd1);
    chk_vec("after_short_data", 16'hA001, 16'hA002, 16'hA003, 16'hA004);
    release_nn();
    chk("after_short_ready", 32'(s_ready_o), 32'd1);

    // Long frame: six words, last on the 6th
    send_word(16'hB001, 1'b0);
    send_word(16'hB002, 1'b0);
    send_word(16'hB003, 1'b0);
    chk("long_err_early", 32'(frame_err_o), 32'd0);
    send_word(16'hB004, 1'b0);
    chk("long_err", 32'(frame_err_o), 32'd1);
    chk("long_fire4", 32'(fire_o), 32'd0);
    chk("long_ready_drain", 32'(s_ready_o), 32'd1);
    send_word(16'hB005, 1'b0);
    chk("long_err_pulse", 32'(frame_err_o), 32'd0);
    chk("long_fire5", 32'(fire_o), 32'd0);
    send_word(16'hB006, 1'b1);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    chk("long_fire6", 32'(fire_o), 32'd0);
    chk("long_err6", 32'(frame_err_o), 32'd0);
    chk("long_ready", 32'(s_ready_o), 32'd1);
    cyc();
    chk("long_fire_after", 32'(fire_o), 32'd0);
    chk_vec("long_data", 16'hB001, 16'hB002, 16'hB003, 16'hB004);

    // Reset mid-frame after two words
    send_word(16'hC001, 1'b0);
    send_word(16'hC002, 1'b0);
    s_valid_i = 1'b0;
    rstn_i    = 1'b0;
    cyc();
    rstn_i = 1'b1;
    chk("mrst_ready", 32'(s_ready_o), 32'd1);
    chk("mrst_fire", 32'(fire_o), 32'd0);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_err", 32'(frame_err_o), 32'd0);
    chk_vec("mrst_data", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    send_frame4(16'hD001, 16'hD002, 16'hD003, 16'hD004);
    chk("mrst_next_fire", 32'(fire_o), 32'd1);
    chk_vec("mrst_next_data", 16'hD001, 16'hD002, 16'hD003, 16'hD004);

    // Reset while waiting on the network
    cyc();
    chk("wrst_busy_pre", 32'(busy_o), 32'd1);
    rstn_i = 1'b0;
    cyc();
    rstn_i = 1'b1;
    chk("wrst_busy", 32'(busy_o), 32'd0);
    chk("wrst_ready", 32'(s_ready_o), 32'd1);
    chk("wrst_fire", 32'(fire_o), 32'd0);
    chk("wrst_timeout", 32'(timeout_o), 32'd0);

`ifdef NN_FRAMER_TIMEOUT_EN
    // Watchdog expiry with no done
    send_frame4(16'hE001, 16'hE002, 16'hE003, 16'hE004);
    chk("to_fire", 32'(fire_o), 32'd1);
    for (int i = 0; i < int'(TO); i++) begin
      cyc();
      chk("to_quiet", 32'(timeout_o), 32'd0);
      chk("to_busy", 32'(busy_o), 32'd1);
    end
    cyc();
    chk("to_pulse", 32'(timeout_o), 32'd1);
    chk("to_ready", 32'(s_ready_o), 32'd1);
    chk("to_busy_off", 32'(busy_o), 32'd0);
    cyc();
    chk("to_pulse_end", 32'(timeout_o), 32'd0);

    // Done on the expiry cycle wins
    send_frame4(16'hF001, 16'hF002, 16'hF003, 16'hF004);
    chk("tod_fire", 32'(fire_o), 32'd1);
    for (int i = 0; i < int'(TO); i++) begin
      cyc();
      chk("tod_quiet", 32'(timeout_o), 32'd0);
    end
    nn_done_i = 1'b1;
    cyc();
    nn_done_i = 1'b0;
    chk("tod_no_timeout", 32'(timeout_o), 32'd0);
    chk("tod_ready", 32'(s_ready_o), 32'd1);
    cyc();
    chk("tod_no_timeout2", 32'(timeout_o), 32'd0);
`else
    // Without the watchdog WAIT holds indefinitely
    send_frame4(16'hE001, 16'hE002, 16'hE003, 16'hE004);
    chk("nto_fire", 32'(fire_o), 32'd1);
    for (int i = 0; i < int'(TO) + 4; i++) begin
      cyc();
      chk("nto_timeout", 32'(timeout_o), 32'd0);
      chk("nto_busy", 32'(busy_o), 32'd1);
    end
    nn_done_i = 1'b1;
    cyc();
    nn_done_i = 1'b0;
    chk("nto_ready", 32'(s_ready_o), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nn_input_framer.md
# nn_input_framer

Upstream stage of the neural network top: turns a serial valid/ready stream of N-bit Q-format feature words into a parallel vector of NUM_OF_INPUTS words. It emits a one-cycle fire pulse when a complete frame is held, then holds the vector stable until the network reports done. Its outputs connect directly to the network's data_in_i/fire_i, and done_o returns to nn_done_i.

## Interface
Parameters:
- Q, 13, fractional bits of the fixed-point format (pass-through only; no arithmetic on values)
- N, 16, word width
- NUM_OF_INPUTS, 4, words per frame (≥2)
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT (used only with NN_FRAMER_TIMEOUT_EN)

Ports (one clock; reset is synchronous and active-low):
- clk_i  in  1  clock, all logic on rising edge
- rstn_i  in  1  synchronous active-low reset
- s_data_i  in  N  feature word
- s_valid_i  in  1  word valid
- s_last_i  in  1  marks final word of a frame, qualified by s_valid_i
- s_ready_o  out  1  framer accepts a word this cycle
- data_out_o  out  N × [0:NUM_OF_INPUTS-1]  feature vector to network
- fire_o  out  1  one-cycle start pulse to network
- nn_done_i  in  1  network finished (level or pulse)
- busy_o  out  1  frame issued, waiting for network
- frame_err_o  out  1  one-cycle pulse on framing error
- timeout_o  out  1  one-cycle pulse on watchdog expiry

## Operation
- Handshake: a transfer occurs when s_valid_i && s_ready_o. s_ready_o is combinational from state: 1 in COLLECT and DRAIN, 0 in FIRE and WAIT.
- States: COLLECT, DRAIN, FIRE, WAIT.
- COLLECT: each transfer writes s_data_i to data_out_o[idx]; idx counts 0..NUM_OF_INPUTS-1 ($clog2 width).
  - Transfer at idx==NUM_OF_INPUTS-1 with s_last_i=1: idx←0, go to FIRE.
  - Transfer with s_last_i=1 at idx<NUM_OF_INPUTS-1 (short frame): frame_err_o pulse, idx←0, stay in COLLECT. Written slots keep their partial data and no fire occurs.
  - Transfer at idx==NUM_OF_INPUTS-1 with s_last_i=0 (long frame): frame_err_o pulse, idx←0, go to DRAIN.
- DRAIN: accept and discard words. A transfer with s_last_i=1 returns to COLLECT. data_out_o is unchanged.
- FIRE: fire_o=1 for exactly this cycle, then WAIT. nn_done_i is ignored in FIRE.
- WAIT: busy_o=1, data_out_o held stable. nn_done_i=1 returns to COLLECT on the next edge.
- busy_o = (state==FIRE || state==WAIT).
- Values are opaque: no sign extension, scaling or saturation.

## Timing
- Reset values: state COLLECT, idx 0, all data_out_o 0, fire_o 0, frame_err_o 0, timeout_o 0, busy_o 0. s_ready_o is 1 in the first cycle after reset.
- Latency: fire_o is high in the cycle after the final-word handshake. The first new word is accepted in the cycle after nn_done_i is sampled high in WAIT.
- Back-to-back minimum frame period: NUM_OF_INPUTS + 2 + network latency.
- fire_o, frame_err_o and timeout_o are registered outputs, each high at most one cycle per event.
- Reset asserted mid-frame or in WAIT abandons the frame. No fire_o and no error pulse are produced.
- s_valid_i while s_ready_o=0: the word is not consumed, and the source must hold it.

## Configuration
- NN_FRAMER_TIMEOUT_EN defined: WAIT runs a cycle counter cleared on WAIT entry.
  - If the counter reaches TIMEOUT_CYCLES-1 without nn_done_i: timeout_o pulses and the state returns to COLLECT.
  - If nn_done_i arrives in the same cycle as expiry, done wins and there is no timeout pulse.
- NN_FRAMER_TIMEOUT_EN undefined: no counter, timeout_o tied 0, WAIT waits indefinitely.

## Structure
- Shared package nn_pkg holds:
  - the state enum typedef framer_state_t (COLLECT, DRAIN, FIRE, WAIT);
  - default N/Q constants shared with the network layers.
- One sub-module: nn_framer_watchdog (counter + expiry pulse), instantiated only under NN_FRAMER_TIMEOUT_EN.

## Test plan
- Reset, then stream 0x2000, 0xE000, 0x1000, 0x0800 (last on the 4th) with valid held high:
  - data_out_o = {0x2000, 0xE000, 0x1000, 0x0800};
  - fire_o high exactly 1 cycle, in the cycle after the 4th handshake;
  - s_ready_o=0 until nn_done_i.
- In WAIT, present a new word with valid for 20 cycles, then pulse nn_done_i: the word is not accepted before done, data_out_o stays unchanged, and the word is accepted 1 cycle after done.
- Short frame with last on the 2nd word: frame_err_o pulses once, no fire_o; the next full 4-word frame fires normally.
- 6-word frame with last on the 6th: frame_err_o pulses at the 4th word; words 5–6 are drained; no fire_o; data_out_o holds words 1–4 of the bad frame.
- Assert rstn_i low for 1 cycle after 2 words: all outputs return to reset values, and the next 4-word frame fires with idx restarted at 0.
- With NN_FRAMER_TIMEOUT_EN and TIMEOUT_CYCLES=8, never assert done: timeout_o pulses 8 cycles after WAIT entry and s_ready_o returns to 1. Repeat with done on the expiry cycle: no timeout_o.
